lock_key_loader: RTL and testbench

- Sequences key delivery to the key-locked c432 netlist: 41 XOR key inputs X_1..X_41 plus 4 MUX select keys p1..p4.
- Receives the key serially over a valid/ready handshake into a shadow register and checks even parity.
- Only a key that passes the check reaches the key bus. Until then the bus is held at all-zero.
- Sits between the on-chip key source (tamper-proof memory reader) and the locked combinational core.

---
 rtl/lock_key_loader.sv | 132 +++++++++++++
 tb/tb_lock_key_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lock_key_loader.sv
// lock_key_loader: receives the locking key for the c432 core serially,
// verifies even parity over key + parity bit, and only then drives the key bus.
// key_out[40:0] -> X_1..X_41, key_out[44:41] -> p1..p4. Bus stays zero until a
// key has been checked.
module lock_key_loader #(
  parameter int KEY_W   = 45,
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             ser_valid,
  input  logic             ser_data,
  output logic             ser_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_CHECK   = 3'd2,
    S_APPLIED = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KEY_W);   // index of the parity beat
  localparam logic [7:0]       TMO_LIM  = 8'(TIMEOUT);

  state_t             state_reg, state_next;
  logic [KEY_W-1:0]   shadow_reg;
  logic [KEY_W-1:0]   key_out_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               parity_reg;
  logic [7:0]         tmo_reg;

  logic               in_shift;
  logic               xfer;
  logic               last_xfer;
  logic               timed_out;
  logic               restart;

  assign in_shift  = (state_reg == S_SHIFT);
  assign xfer      = in_shift && ser_valid;
  assign last_xfer = xfer && (cnt_reg == LAST_CNT);
  assign timed_out = in_shift && (tmo_reg == TMO_LIM);
  // A load request is honoured everywhere except the single CHECK cycle.
  assign restart   = load_start && (state_reg != S_CHECK);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    state_next = state_reg;
    ser_ready  = 1'b0;
    busy       = 1'b0;
    key_valid  = 1'b0;
    err        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (load_start) state_next = S_SHIFT;
      end
      S_SHIFT: begin
        ser_ready = 1'b1;
        busy      = 1'b1;
        if (load_start)     state_next = S_SHIFT;
        else if (timed_out) state_next = S_ERROR;
        else if (last_xfer) state_next = S_CHECK;
      end
      S_CHECK: begin
        busy       = 1'b1;
        state_next = parity_reg ? S_ERROR : S_APPLIED;
      end
      S_APPLIED: begin
        key_valid = 1'b1;
        if (load_start) state_next = S_SHIFT;
      end
      S_ERROR: begin
        err = 1'b1;
        if (load_start) state_next = S_SHIFT;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Bit counter, parity accumulator and idle-cycle counter for the serial link.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt_reg    <= '0;
      parity_reg <= 1'b0;
      tmo_reg    <= '0;
    end else if (in_shift) begin
      if (xfer) begin
        cnt_reg    <= cnt_reg + 1'b1;
        parity_reg <= parity_reg ^ ser_data;
        tmo_reg    <= '0;
      end else if (!timed_out) begin
        tmo_reg    <= tmo_reg + 1'b1;
      end
    end
  end

  // Shadow register: each bit captures the serial bit whose index it owns.
  generate
    for (genvar gi = 0; gi < KEY_W; gi++) begin : g_shadow
      always_ff @(posedge clk) begin
        if (rst || restart)
          shadow_reg[gi] <= 1'b0;
        else if (xfer && (cnt_reg == CNT_W'(gi)))
          shadow_reg[gi] <= ser_data;
      end
    end
  endgenerate

  // Key bus: cleared when a load starts, loaded only when the check passes.
  always_ff @(posedge clk) begin
    if (rst || restart)
      key_out_reg <= '0;
    else if (state_reg == S_CHECK && !parity_reg)
      key_out_reg <= shadow_reg;
  end

  assign key_out = key_out_reg;

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed testbench for lock_key_loader: checks reset, good/bad parity loads,
// timeout, restart, mid-load reset, CHECK-cycle load_start and gapped loads.
module tb_lock_key_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        ser_valid;
  logic        ser_data;
  logic        ser_ready;
  logic [44:0] key_out;
  logic        key_valid;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  lock_key_loader #(.KEY_W(45), .CNT_W(6), .TIMEOUT(255)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_start(load_start),
    .ser_valid (ser_valid),
    .ser_data  (ser_data),
    .ser_ready (ser_ready),
    .key_out   (key_out),
    .key_valid (key_valid),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Invariants checked on every falling edge outside reset.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (key_valid !== 1'b1) check("key_hidden", {19'b0, key_out}, 64'd0);
      if (busy !== 1'b1)      check("ready_only_busy", {63'b0, ser_ready}, 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1; tick(); load_start = 1'b0;
  endtask

  // Send bits 0..n-1 of k back to back, leave ser_valid low afterwards.
  task automatic send_bits(input logic [44:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      ser_valid = 1'b1; ser_data = k[i]; tick();
    end
    ser_valid = 1'b0;
  endtask

  // Full 46-beat load with optional random idle gaps before each beat.
  task automatic send_key(input logic [44:0] k, input logic p, input int maxgap);
    for (int i = 0; i < 46; i++) begin
      if (maxgap > 0) begin
        int g;
        g = $urandom_range(0, maxgap);
        ser_valid = 1'b0;
        for (int j = 0; j < g; j++) tick();
      end
      ser_valid = 1'b1;
      ser_data  = (i < 45) ? k[i] : p;
      tick();
    end
    ser_valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic [44:0] kexp, input logic kv,
                               input logic bz, input logic er, input logic rdy);
    check({tag, "_key"},   {19'b0, key_out},   {19'b0, kexp});
    check({tag, "_valid"}, {63'b0, key_valid}, {63'b0, kv});
    check({tag, "_busy"},  {63'b0, busy},      {63'b0, bz});
    check({tag, "_err"},   {63'b0, err},       {63'b0, er});
    check({tag, "_ready"}, {63'b0, ser_ready}, {63'b0, rdy});
  endtask

  localparam logic [44:0] K_ONES = 45'h1FFF_FFFF_FFFF;
  localparam logic [44:0] K_EDGE = 45'h1000_0000_0001;
  localparam logic [44:0] K_A    = 45'h0A5A_5C3C_96E1;
  localparam logic [44:0] K_B    = 45'h1234_5678_9ABC;

  initial begin
    logic [44:0] rk;
    rst = 1'b1; load_start = 1'b0; ser_valid = 1'b0; ser_data = 1'b0;
    tick(); tick();
    check_outputs("reset", 45'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check_outputs("idle", 45'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // All ones: 46 ones total, even parity.
    pulse_start();
    check_outputs("shift", 45'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_key(K_ONES, 1'b1, 0);
    check_outputs("check", 45'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check_outputs("ones", K_ONES, 1'b1, 1'b0, 1'b0, 1'b0);

    // X_1 and p4 set, parity 0; load_start in CHECK must be ignored.
    pulse_start();
    check("restart_clears_key", {19'b0, key_out}, 64'd0);
    send_key(K_EDGE, 1'b0, 0);
    load_start = 1'b1; tick(); load_start = 1'b0;
    check_outputs("edge", K_EDGE, 1'b1, 1'b0, 1'b0, 1'b0);
    check("edge_pbits", {60'b0, key_out[44:41]}, 64'h8);
    // Serial input while APPLIED has no effect.
    send_bits(45'h0, 8);
    check_outputs("applied_hold", K_EDGE, 1'b1, 1'b0, 1'b0, 1'b0);

    // Same key with bad parity -> ERROR, then a good load recovers.
    pulse_start();
    send_key(K_EDGE, 1'b1, 0);
    tick();
    check_outputs("bad_par", 45'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_start();
    check("err_cleared", {63'b0, err}, 64'd0);
    send_key(K_A, ^K_A, 0);
    tick();
    check_outputs("recover", K_A, 1'b1, 1'b0, 1'b0, 1'b0);

    // Timeout: 10 bits, then 256 idle cycles.
    pulse_start();
    send_bits(K_B, 10);
    repeat (254) tick();
    check_outputs("tmo_254", 45'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(); tick();
    check_outputs("tmo_err", 45'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Stall of 254 cycles then resume completes normally.
    pulse_start();
    send_bits(K_B, 10);
    repeat (254) tick();
    for (int i = 10; i < 46; i++) begin
      ser_valid = 1'b1; ser_data = (i < 45) ? K_B[i] : ^K_B; tick();
    end
    ser_valid = 1'b0;
    tick();
    check_outputs("stall_ok", K_B, 1'b1, 1'b0, 1'b0, 1'b0);

    // Restart coinciding with bit 30: bit dropped, fresh 46 beats needed.
    pulse_start();
    send_bits(K_A, 30);
    load_start = 1'b1; ser_valid = 1'b1; ser_data = 1'b1; tick();
    load_start = 1'b0; ser_valid = 1'b0;
    send_bits(K_B, 45);
    check_outputs("restart_45", 45'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    ser_valid = 1'b1; ser_data = ^K_B; tick(); ser_valid = 1'b0;
    tick();
    check_outputs("restart_key", K_B, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a load.
    pulse_start();
    send_bits(K_A, 20);
    rst = 1'b1; tick(); rst = 1'b0;
    check_outputs("mid_rst", 45'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random keys with random gaps.
    for (int r = 0; r < 3; r++) begin
      rk = {$urandom(), $urandom()} & 45'h1FFF_FFFF_FFFF;
      pulse_start();
      send_key(rk, ^rk, 6);
      check("rnd_ready_check", {63'b0, ser_ready}, 64'd0);
      tick();
      check_outputs($sformatf("rnd%0d", r), rk, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
